fb_write_arb: RTL

Arbiter that shares the single framebuffer write port (`fb_we`/`fb_wadr`/`fb_d`) between two requesters: the CPU write path (m0) and the text-blitter that renders `textbuf` glyphs into pixels (m1). It sits between those sources and the framebuffer inside `vdp`. It grants one pixel write per clock using round-robin with a bounded burst length, and registers the winning write onto the framebuffer port. A `hold` input freezes all grants during frame-swap or configuration.

---
 rtl/fb_write_arb_if.sv | 43 ++++
 rtl/fb_write_arb.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fb_write_arb_if.sv
// ============================================================================
//  Module : fb_write_arb_if
//  Brief  : Request/accept and framebuffer-write bundle for fb_write_arb.
//           master = requester/observer side, slave = arbiter side.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fb_write_arb_if #(
  parameter int AW = 16,
  parameter int DW = 24
);
  // CPU write path
  logic          m0_valid;
  logic          m0_ready;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_d;
  // Text blitter
  logic          m1_valid;
  logic          m1_ready;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_d;
  // Registered framebuffer write port
  logic          fb_we;
  logic [AW-1:0] fb_wadr;
  logic [DW-1:0] fb_d;

  modport master (
    output m0_valid, m0_adr, m0_d,
    output m1_valid, m1_adr, m1_d,
    input  m0_ready, m1_ready,
    input  fb_we, fb_wadr, fb_d
  );

  modport slave (
    input  m0_valid, m0_adr, m0_d,
    input  m1_valid, m1_adr, m1_d,
    output m0_ready, m1_ready,
    output fb_we, fb_wadr, fb_d
  );
endinterface

`default_nettype wire

// File: rtl/fb_write_arb.sv
// ============================================================================
//  Module : fb_write_arb
//  Brief  : Round-robin arbiter with bounded burst sharing the single
//           framebuffer write port between the CPU (m0) and the text
//           blitter (m1). One registered pixel write per clock.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_write_arb #(
  parameter  int AW    = 16,
  parameter  int DW    = 24,
  parameter  int BURST = 4,
  localparam int CW    = $clog2(BURST + 1)
) (
  input  wire logic          CLOCK_50,
  input  wire logic          rst,        // asynchronous, active low
  input  wire logic          hold,
  fb_write_arb_if.slave      bus,
  output logic [1:0]         owner,
  output logic [CW-1:0]      burst_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  localparam logic [CW-1:0] c_burst = CW'(BURST);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;    // id of the most recently granted requester

  logic          fb_we_q;
  logic [AW-1:0] fb_wadr_q;
  logic [DW-1:0] fb_d_q;

  logic          w_grant0;
  logic          w_grant1;
  logic [CW-1:0] w_cnt_inc;

  // Grant selection: the owner keeps the port until its burst is spent while
  // the other side waits; from IDLE a tie goes to whoever was not served last.
  // Grants are also suppressed while reset is asserted.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (rst && !hold) begin
      case (state_q)
        S_OWN0: begin
          if (bus.m0_valid && ((cnt_q < c_burst) || !bus.m1_valid)) w_grant0 = 1'b1;
          else if (bus.m1_valid)                                    w_grant1 = 1'b1;
        end
        S_OWN1: begin
          if (bus.m1_valid && ((cnt_q < c_burst) || !bus.m0_valid)) w_grant1 = 1'b1;
          else if (bus.m0_valid)                                    w_grant0 = 1'b1;
        end
        default: begin
          if (bus.m0_valid && bus.m1_valid) begin
            if (last_q) w_grant0 = 1'b1;
            else        w_grant1 = 1'b1;
          end else if (bus.m0_valid) begin
            w_grant0 = 1'b1;
          end else if (bus.m1_valid) begin
            w_grant1 = 1'b1;
          end
        end
      endcase
    end
  end

  // Burst counter increment, saturating at BURST for a lone requester
  always_comb begin
    w_cnt_inc = (cnt_q >= c_burst) ? c_burst : cnt_q + CW'(1);
  end

  // Next arbitration state; hold freezes everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (!hold) begin
      if (w_grant0) begin
        state_d = S_OWN0;
        cnt_d   = (state_q == S_OWN0) ? w_cnt_inc : CW'(1);
        last_d  = 1'b0;
      end else if (w_grant1) begin
        state_d = S_OWN1;
        cnt_d   = (state_q == S_OWN1) ? w_cnt_inc : CW'(1);
        last_d  = 1'b1;
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Arbitration state registers; last resets to 1 so m0 wins the first tie
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Output register: capture the winning write; address/data hold when idle
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      fb_we_q   <= 1'b0;
      fb_wadr_q <= '0;
      fb_d_q    <= '0;
    end else begin
      fb_we_q <= w_grant0 | w_grant1;
      if (w_grant0) begin
        fb_wadr_q <= bus.m0_adr;
        fb_d_q    <= bus.m0_d;
      end else if (w_grant1) begin
        fb_wadr_q <= bus.m1_adr;
        fb_d_q    <= bus.m1_d;
      end
    end
  end

  assign bus.m0_ready = w_grant0;
  assign bus.m1_ready = w_grant1;
  assign bus.fb_we    = fb_we_q;
  assign bus.fb_wadr  = fb_wadr_q;
  assign bus.fb_d     = fb_d_q;
  assign owner        = state_q;
  assign burst_cnt    = cnt_q;

endmodule

`default_nettype wire
